// File: rtl/snn_mac_pkg.sv
// Shared constants and helpers for the SNN multiply-accumulate pipe.
// Optional saturation is enabled by defining SNN_MAC_SAT_EN.
package snn_mac_pkg;

    localparam int unsigned ACC_W_DEF = 26;

    // Exact width of a LANES-wide signed dot product of IN_W-bit operands.
    function automatic int unsigned prod_w(input int unsigned in_w, input int unsigned lanes);
        return 2 * in_w + $clog2(lanes);
    endfunction

    function automatic logic signed [63:0] sat_max(input int unsigned w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int unsigned w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/snn_mac_pipe_if.sv
// Operand-beat and result handshake bundle for snn_mac_pipe.
// master = fetch/consumer side, slave = the MAC engine.
interface snn_mac_pipe_if
    import snn_mac_pkg::*;
#(
    parameter int unsigned IN_W  = 8,
    parameter int unsigned LANES = 1,
    parameter int unsigned ACC_W = ACC_W_DEF
);
    logic                     in_vld;
    logic                     in_rdy;
    logic                     in_last;
    logic [LANES*IN_W-1:0]    in1;
    logic [LANES*IN_W-1:0]    in2;
    logic signed [ACC_W-1:0]  acc;
    logic                     res_vld;
    logic                     res_rdy;
    logic signed [ACC_W-1:0]  res;
    logic                     res_ovf;

    modport master (
        output in_vld, in_last, in1, in2, res_rdy,
        input  in_rdy, acc, res_vld, res, res_ovf
    );

    modport slave (
        input  in_vld, in_last, in1, in2, res_rdy,
        output in_rdy, acc, res_vld, res, res_ovf
    );
endinterface

// File: rtl/snn_mac_dot.sv
// Combinational LANES-wide signed multiply and sum, feeding the stage-1 register.
module snn_mac_dot
    import snn_mac_pkg::*;
#(
    parameter int unsigned IN_W  = 8,
    parameter int unsigned LANES = 1,
    localparam int unsigned PW   = prod_w(IN_W, LANES)
) (
    input  logic [LANES*IN_W-1:0] in1,
    input  logic [LANES*IN_W-1:0] in2,
    output logic signed [PW-1:0]  sum
);
    logic signed [PW-1:0] a;
    logic signed [PW-1:0] b;

    // Operands are widened to PW first so the product and the sum never lose bits.
    always_comb begin
        sum = '0;
        a   = '0;
        b   = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            a   = {{(PW-IN_W){in1[i*IN_W+IN_W-1]}}, in1[i*IN_W +: IN_W]};
            b   = {{(PW-IN_W){in2[i*IN_W+IN_W-1]}}, in2[i*IN_W +: IN_W]};
            sum = sum + a * b;
        end
    end
endmodule

// File: rtl/snn_mac_pipe.sv
// Two-stage pipelined signed dot-product accumulator with valid/ready result port.
// Define SNN_MAC_SAT_EN for saturating accumulation with sticky overflow reporting.
module snn_mac_pipe
    import snn_mac_pkg::*;
#(
    parameter int unsigned IN_W  = 8,
    parameter int unsigned LANES = 1,
    parameter int unsigned ACC_W = ACC_W_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_n,
    snn_mac_pipe_if.slave bus
);
    localparam int unsigned PW = prod_w(IN_W, LANES);

    if (ACC_W < PW) begin : g_acc_w_chk
        $error("snn_mac_pipe: ACC_W narrower than 2*IN_W+clog2(LANES)");
    end

    logic signed [PW-1:0]    dot_sum;
    logic                    stall, in_rdy, accept, fire;
    logic                    s1_vld_q, s1_vld_d, s1_last_q, s1_last_d;
    logic signed [ACC_W-1:0] s1_sum_q, s1_sum_d;
    logic signed [ACC_W-1:0] acc_q, acc_d, res_q, res_d;
    logic signed [ACC_W-1:0] sum_raw, nxt;
    logic                    res_vld_q, res_vld_d;

    snn_mac_dot #(
        .IN_W  (IN_W),
        .LANES (LANES)
    ) u_dot (
        .in1 (bus.in1),
        .in2 (bus.in2),
        .sum (dot_sum)
    );

    assign stall  = res_vld_q & ~bus.res_rdy;
    assign in_rdy = rst_n & clr_n & ~stall;
    assign accept = bus.in_vld & in_rdy;
    assign fire   = s1_vld_q & ~stall;

    assign sum_raw = acc_q + s1_sum_q;

`ifdef SNN_MAC_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(sat_max(ACC_W));
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(sat_min(ACC_W));

    logic ovf_this, ovf_q, ovf_d, res_ovf_q, res_ovf_d;

    assign ovf_this = (acc_q[ACC_W-1] == s1_sum_q[ACC_W-1]) &&
                      (sum_raw[ACC_W-1] != acc_q[ACC_W-1]);
    assign nxt      = ovf_this ? (acc_q[ACC_W-1] ? SAT_MIN : SAT_MAX) : sum_raw;

    always_comb begin
        ovf_d     = ovf_q;
        res_ovf_d = res_ovf_q;
        if (!clr_n) begin
            ovf_d = 1'b0;
        end else if (fire) begin
            if (s1_last_q) begin
                res_ovf_d = ovf_q | ovf_this;
                ovf_d     = 1'b0;
            end else begin
                ovf_d = ovf_q | ovf_this;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q     <= 1'b0;
            res_ovf_q <= 1'b0;
        end else begin
            ovf_q     <= ovf_d;
            res_ovf_q <= res_ovf_d;
        end
    end

    assign bus.res_ovf = res_ovf_q;
`else
    assign nxt         = sum_raw;
    assign bus.res_ovf = 1'b0;
`endif

    // Stage 1 holds its contents while the result port is stalled.
    always_comb begin
        s1_vld_d  = s1_vld_q;
        s1_last_d = s1_last_q;
        s1_sum_d  = s1_sum_q;
        if (!clr_n) begin
            s1_vld_d = 1'b0;
        end else if (!stall) begin
            s1_vld_d = accept;
            if (accept) begin
                s1_last_d = bus.in_last;
                s1_sum_d  = ACC_W'(dot_sum);
            end
        end
    end

    always_comb begin
        acc_d     = acc_q;
        res_d     = res_q;
        res_vld_d = res_vld_q;
        if (res_vld_q && bus.res_rdy) begin
            res_vld_d = 1'b0;
        end
        if (fire) begin
            if (s1_last_q) begin
                res_d     = nxt;
                res_vld_d = 1'b1;
                acc_d     = '0;
            end else begin
                acc_d = nxt;
            end
        end
        if (!clr_n) begin
            acc_d     = '0;
            res_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s1_last_q <= 1'b0;
            s1_sum_q  <= '0;
            acc_q     <= '0;
            res_q     <= '0;
            res_vld_q <= 1'b0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_last_q <= s1_last_d;
            s1_sum_q  <= s1_sum_d;
            acc_q     <= acc_d;
            res_q     <= res_d;
            res_vld_q <= res_vld_d;
        end
    end

    assign bus.in_rdy  = in_rdy;
    assign bus.acc     = acc_q;
    assign bus.res     = res_q;
    assign bus.res_vld = res_vld_q;
endmodule

// File: tb/tb_snn_mac_pipe.sv
// Directed self-checking bench for snn_mac_pipe: a LANES=1 instance and a LANES=4 instance.
module tb_snn_mac_pipe;
    logic clk;
    logic rst_n;
    logic clr_n;
    int   n_checks;
    int   n_fail;

    snn_mac_pipe_if #(.IN_W(8), .LANES(1), .ACC_W(26)) if1 ();
    snn_mac_pipe_if #(.IN_W(8), .LANES(4), .ACC_W(20)) if4 ();

    snn_mac_pipe #(.IN_W(8), .LANES(1), .ACC_W(26)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_n (clr_n),
        .bus   (if1.slave)
    );

    snn_mac_pipe #(.IN_W(8), .LANES(4), .ACC_W(20)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_n (clr_n),
        .bus   (if4.slave)
    );

    always #10 clk = ~clk;

    task automatic check_eq(input string tag, input logic signed [63:0] obs,
                            input logic signed [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present one beat on the LANES=1 port; returns 1 time unit after the accepting edge.
    task automatic beat1(input logic signed [7:0] a, input logic signed [7:0] b,
                         input logic last);
        int n;
        n = 0;
        if1.in_vld  = 1'b1;
        if1.in1     = a;
        if1.in2     = b;
        if1.in_last = last;
        while (!if1.in_rdy && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) check_eq("beat_rdy_timeout", 64'(if1.in_rdy), 1);
        @(posedge clk);
        #1;
        if1.in_vld  = 1'b0;
        if1.in_last = 1'b0;
    endtask

    task automatic wait_res1(input string tag);
        int n;
        n = 0;
        while (!if1.res_vld && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq({tag, "_vld"}, 64'(if1.res_vld), 1);
    endtask

    logic signed [63:0] exp_ovf_res;
    logic [63:0]        exp_ovf_flag;
    int                 n4;

    initial begin
        n_checks     = 0;
        n_fail       = 0;
`ifdef SNN_MAC_SAT_EN
        exp_ovf_res  = 33554431;
        exp_ovf_flag = 1;
`else
        exp_ovf_res  = -33554432;
        exp_ovf_flag = 0;
`endif
        clk = 1'b0;
        rst_n = 1'b1;
        clr_n = 1'b1;
        if1.in_vld = 1'b0; if1.in_last = 1'b0; if1.in1 = '0; if1.in2 = '0; if1.res_rdy = 1'b1;
        if4.in_vld = 1'b0; if4.in_last = 1'b0; if4.in1 = '0; if4.in2 = '0; if4.res_rdy = 1'b1;
        #2 rst_n = 1'b0;
        #3;
        check_eq("rst_in_rdy", 64'(if1.in_rdy), 0);
        check_eq("rst_res_vld", 64'(if1.res_vld), 0);
        check_eq("rst_res", if1.res, 0);
        check_eq("rst_acc", if1.acc, 0);
        check_eq("rst_res_ovf", 64'(if1.res_ovf), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 check_eq("post_rst_in_rdy", 64'(if1.in_rdy), 1);

        // in_last without in_vld must be ignored
        if1.in_last = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("last_no_vld_res_vld", 64'(if1.res_vld), 0);
        if1.in_last = 1'b0;

        // Basic vector and exact two-cycle latency
        beat1(3, 4, 1'b0);
        beat1(-5, 6, 1'b0);
        beat1(127, 127, 1'b1);
        check_eq("basic_vld_t1", 64'(if1.res_vld), 0);
        @(posedge clk);
        #1;
        check_eq("basic_vld_t2", 64'(if1.res_vld), 1);
        check_eq("basic_res", if1.res, 16111);
        check_eq("basic_acc_clr", if1.acc, 0);
        @(posedge clk);
        #1;
        check_eq("basic_vld_drop", 64'(if1.res_vld), 0);

        // Back-to-back single-beat vectors
        beat1(1, 1, 1'b1);
        beat1(2, 2, 1'b1);
        check_eq("b2b_res0", if1.res, 1);
        check_eq("b2b_vld0", 64'(if1.res_vld), 1);
        @(posedge clk);
        #1;
        check_eq("b2b_res1", if1.res, 4);
        check_eq("b2b_vld1", 64'(if1.res_vld), 1);
        @(posedge clk);
        #1;

        // Overflow across 2048 beats of (-128,-128)
        for (int i = 0; i < 2048; i++) beat1(-128, -128, (i == 2047));
        wait_res1("ovf");
        check_eq("ovf_res", if1.res, exp_ovf_res);
        check_eq("ovf_flag", 64'(if1.res_ovf), exp_ovf_flag);
        beat1(1, 1, 1'b1);
        wait_res1("post_ovf");
        check_eq("post_ovf_res", if1.res, 1);
        check_eq("post_ovf_flag", 64'(if1.res_ovf), 0);
        @(posedge clk);
        #1;

        // Backpressure
        if1.res_rdy = 1'b0;
        beat1(2, 5, 1'b1);
        wait_res1("bp_a");
        check_eq("bp_a_res", if1.res, 10);
        if1.in_vld = 1'b1; if1.in1 = 8'd2; if1.in2 = 8'd3; if1.in_last = 1'b1;
        #1;
        check_eq("bp_in_rdy", 64'(if1.in_rdy), 0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("bp_hold_res", if1.res, 10);
        check_eq("bp_hold_vld", 64'(if1.res_vld), 1);
        check_eq("bp_in_rdy2", 64'(if1.in_rdy), 0);
        if1.res_rdy = 1'b1;
        #1;
        check_eq("bp_release_rdy", 64'(if1.in_rdy), 1);
        @(posedge clk);
        #1;
        if1.in_vld = 1'b0; if1.in_last = 1'b0;
        check_eq("bp_a_consumed", 64'(if1.res_vld), 0);
        @(posedge clk);
        #1;
        check_eq("bp_b_vld", 64'(if1.res_vld), 1);
        check_eq("bp_b_res", if1.res, 6);
        @(posedge clk);
        #1;

        // Synchronous clear drops the pending beat and the accumulator
        beat1(10, 10, 1'b0);
        beat1(10, 10, 1'b0);
        check_eq("clr_pre_acc", if1.acc, 100);
        clr_n = 1'b0;
        if1.in_vld = 1'b1; if1.in1 = 8'd10; if1.in2 = 8'd10;
        #1;
        check_eq("clr_in_rdy", 64'(if1.in_rdy), 0);
        @(posedge clk);
        #1;
        check_eq("clr_acc", if1.acc, 0);
        clr_n = 1'b1;
        if1.in_vld = 1'b0;
        @(posedge clk);
        #1;
        check_eq("clr_no_accept_acc", if1.acc, 0);
        beat1(1, 2, 1'b1);
        wait_res1("clr_post");
        check_eq("clr_post_res", if1.res, 2);

        // Async reset mid-vector
        beat1(5, 5, 1'b0);
        beat1(5, 5, 1'b0);
        @(posedge clk);
        #1;
        check_eq("mid_vec_acc", if1.acc, 50);
        #3 rst_n = 1'b0;
        #1;
        check_eq("rst_mv_acc", if1.acc, 0);
        check_eq("rst_mv_res", if1.res, 0);
        check_eq("rst_mv_in_rdy", 64'(if1.in_rdy), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Async reset while stalled on an unconsumed result
        if1.res_rdy = 1'b0;
        beat1(3, 3, 1'b1);
        wait_res1("stall");
        check_eq("stall_res", if1.res, 9);
        #3 rst_n = 1'b0;
        #1;
        check_eq("rst_st_res", if1.res, 0);
        check_eq("rst_st_vld", 64'(if1.res_vld), 0);
        check_eq("rst_st_in_rdy", 64'(if1.in_rdy), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        if1.res_rdy = 1'b1;
        beat1(4, -4, 1'b1);
        wait_res1("post_rst");
        check_eq("post_rst_res", if1.res, -16);
        check_eq("post_rst_acc", if1.acc, 0);

        // Four-lane instance: 1 + 4 - 9 + 16384
        if4.in1 = 32'h80FD_0201;
        if4.in2 = 32'h8003_0201;
        if4.in_vld = 1'b1;
        if4.in_last = 1'b1;
        #1;
        check_eq("l4_in_rdy", 64'(if4.in_rdy), 1);
        @(posedge clk);
        #1;
        if4.in_vld = 1'b0;
        if4.in_last = 1'b0;
        n4 = 0;
        while (!if4.res_vld && n4 < 20) begin
            @(posedge clk);
            #1;
            n4++;
        end
        check_eq("l4_vld", 64'(if4.res_vld), 1);
        check_eq("l4_res", if4.res, 16380);
        check_eq("l4_acc", if4.acc, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/snn_mac_pipe.md
Name: snn_mac_pipe

Overview:
Parametrised, two-stage pipelined multiply-accumulate engine for SNN neuron evaluation. It computes a signed dot product over LANES operand pairs per beat. It accumulates beats until a beat tagged last arrives, then emits the finished sum on a valid/ready result port and auto-clears for the next vector. It sits between the weight/input fetch logic and the activation/threshold stage.

Parameters:
IN_W, 8, width of each signed operand lane.
LANES, 1, operand pairs multiplied and summed per beat.
ACC_W, 26, signed accumulator/result width; must be >= 2*IN_W+$clog2(LANES) (elaboration-time assertion).

Ports:
clk  input  1  system clock, 50 MHz.
rst_n  input  1  reset, asynchronous, active-low.
clr_n  input  1  synchronous active-low flush/clear.
in_vld  input  1  operand beat valid.
in_rdy  output  1  engine can accept a beat.
in_last  input  1  beat is final term of the current vector.
in1  input  LANES*IN_W  signed operand lanes; lane i = [i*IN_W +: IN_W].
in2  input  LANES*IN_W  signed operand lanes, same packing.
acc  output  ACC_W  running accumulator (debug/observe).
res_vld  output  1  result valid.
res_rdy  input  1  downstream accepts result.
res  output  ACC_W  completed signed dot product.
res_ovf  output  1  overflow occurred in the vector that produced res.

Behaviour:
- Reset (rst_n low, any time, including mid-vector): s1_vld=0, acc=0, ovf sticky=0, res=0, res_vld=0, res_ovf=0. in_rdy=0 while rst_n low.
- stall = res_vld & ~res_rdy. in_rdy = clr_n & ~stall. Beat accepted when in_vld & in_rdy.
- Stage 1 (registered): per-lane signed product, lanes summed into PW=2*IN_W+$clog2(LANES) bits, sign-extended to ACC_W; captures s1_vld and s1_last. Holds all contents while stall.
- Stage 2: when s1_vld & ~stall, compute nxt = acc + s1_sum.
  - If ~s1_last: acc<=nxt.
  - If s1_last: res<=nxt, res_ovf<=ovf|ovf_this, res_vld<=1, acc<=0, sticky ovf<=0.
- Overflow detection: operands share a sign and nxt's sign differs from it.
- res_vld clears on res_vld & res_rdy unless a new result loads in the same cycle. Back-to-back results are allowed when res_rdy is held high.
- Latency: last beat accepted in cycle t -> res_vld high in cycle t+2. Throughput: 1 beat/cycle when not stalled.
- While stall, the whole pipe freezes: no acceptance, stage 1 held, acc unchanged.
- clr_n low (sync, highest priority after rst_n): s1_vld<=0, acc<=0, sticky ovf<=0, res_vld<=0. Concurrent input beat is not accepted, because in_rdy is low.
- Single-beat vector (in_last on first beat): res = that beat's product sum.
- in_last with in_vld low is ignored.

Optional Feature:
SNN_MAC_SAT_EN
- Defined: on overflow, nxt is clamped to +(2^(ACC_W-1)-1) or -2^(ACC_W-1) according to operand sign; subsequent beats continue from the clamped value; res_ovf reports sticky overflow.
- Undefined: two's-complement wrap modulo 2^ACC_W; overflow logic removed and res_ovf tied 0.

Decomposition:
- Package snn_mac_pkg:
  - function prod_w(IN_W,LANES) returning 2*IN_W+$clog2(LANES).
  - ACC_W default constant (26).
  - saturation-limit functions sat_max(w) and sat_min(w).
- Sub-module snn_mac_dot: combinational LANES-wide signed multiply and adder tree, instantiated ahead of the stage-1 register.

Test Plan:
- Basic vector, LANES=1: beats (3,4), (-5,6), (127,127,last), res_rdy=1 -> res=16111, res_vld exactly 2 cycles after last beat, acc=0 next cycle.
- Overflow: 2048 beats of (-128,-128), last on 2048th. With SNN_MAC_SAT_EN -> res=33554431, res_ovf=1. Without -> res=-33554432, res_ovf=0. Next vector (1,1,last) -> res=1, res_ovf=0.
- Backpressure: res_rdy=0 after vector A(sum 10) completes; present vector B (2,3,last) -> in_rdy=0 and res holds 10. Raise res_rdy -> 10 consumed, B accepted, res=6 two cycles later.
- clr_n: beats (10,10),(10,10) then clr_n low 1 cycle with in_vld high -> acc=0, beat not accepted. Then (1,2,last) -> res=2.
- rst_n asserted asynchronously mid-vector and mid-stall -> all outputs 0 immediately. After release, (4,-4,last) -> res=-16.
- LANES=4, ACC_W=20: lanes (1,1),(2,2),(-3,3),(-128,-128) last -> res=16380.
